// File: rtl/fifo_pkg.sv
// Shared helpers for the single-clock SDP RAM FIFO.
// Depth derivation and parameter sanity helpers.
package fifo_pkg;

  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r++;
      x = x >> 1;
    end
    return r;
  endfunction

  function automatic int fifo_depth(input int aw);
    return 1 << aw;
  endfunction

  function automatic bit af_th_ok(input int aw, input int th);
    return th <= fifo_depth(aw);
  endfunction

  function automatic bit ae_th_ok(input int aw, input int th);
    return th < fifo_depth(aw);
  endfunction

endpackage

// File: rtl/sdpram_sc.sv
// Single-clock simple dual-port RAM, registered read port.
// The array itself is never reset; only the read register is.
module sdpram_sc
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 20,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port into the array
  always_ff @(posedge clk) begin
    if (wr_en) r_mem[wr_addr] <= wr_data;
  end

  // Registered read port, holds when not reading
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_data <= '0;
    end else if (rd_en) begin
      r_rd_data <= r_mem[rd_addr];
    end
  end

  assign rd_data = r_rd_data;

endmodule

// File: rtl/sync_fifo_sdpram.sv
// Parametrised single-clock FIFO on an inferred SDP RAM.
// Standard or first-word-fall-through read, registered flags.
module sync_fifo_sdpram
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 20,
  parameter int ADDR_WIDTH      = 8,
  parameter int FWFT            = 0,
  parameter int ALMOST_FULL_TH  = (1 << ADDR_WIDTH) - 4,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  full,
  output logic                  almost_full,
  output logic                  overflow,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  empty,
  output logic                  almost_empty,
  output logic                  underflow,
  output logic [ADDR_WIDTH:0]   data_count
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] C_DEPTH = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] C_AF = (ADDR_WIDTH+1)'(ALMOST_FULL_TH);
  localparam logic [ADDR_WIDTH:0] C_AE = (ADDR_WIDTH+1)'(ALMOST_EMPTY_TH);
  localparam logic [ADDR_WIDTH:0] C_ONE = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] P_ONE = ADDR_WIDTH'(1);

  if (ADDR_WIDTH < 1) begin : g_bad_aw
    $error("ADDR_WIDTH must be at least 1");
  end
  if (!af_th_ok(ADDR_WIDTH, ALMOST_FULL_TH)) begin : g_bad_af
    $error("ALMOST_FULL_TH exceeds DEPTH");
  end
  if (!ae_th_ok(ADDR_WIDTH, ALMOST_EMPTY_TH)) begin : g_bad_ae
    $error("ALMOST_EMPTY_TH must be below DEPTH");
  end

  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_cnt;
  logic [ADDR_WIDTH:0]   r_ram_cnt;
  logic                  r_full;
  logic                  r_afull;
  logic                  r_empty;
  logic                  r_aempty;
  logic                  r_ovf;
  logic                  r_udf;
  logic                  r_ovalid;
  logic                  r_mvalid;
  logic [DATA_WIDTH-1:0] r_dout;

  logic                  w_push;
  logic                  w_pop;
  logic                  w_rd;
  logic                  w_load;
  logic                  w_ovalid_n;
  logic                  w_mvalid_n;
  logic                  w_empty_n;
  logic [ADDR_WIDTH:0]   w_cnt_n;
  logic [ADDR_WIDTH:0]   w_ram_cnt_n;
  logic [DATA_WIDTH-1:0] w_ram_rdata;

  // Accept logic, prefetch decisions and next occupancy
  always_comb begin
    w_push = wr_en & ~r_full;
    w_pop  = rd_en & ~r_empty;
    w_load = (~r_ovalid | w_pop) & r_mvalid;
    w_rd   = w_pop;
    if (FWFT != 0) begin
      w_rd = (~r_mvalid | w_load) & (r_ram_cnt != '0);
    end
    w_ovalid_n = w_load | (r_ovalid & ~w_pop);
    w_mvalid_n = w_rd | (r_mvalid & ~w_load);
    w_cnt_n = r_cnt;
    if (w_push & ~w_pop) w_cnt_n = r_cnt + C_ONE;
    else if (~w_push & w_pop) w_cnt_n = r_cnt - C_ONE;
    w_ram_cnt_n = r_ram_cnt;
    if (w_push & ~w_rd) w_ram_cnt_n = r_ram_cnt + C_ONE;
    else if (~w_push & w_rd) w_ram_cnt_n = r_ram_cnt - C_ONE;
    w_empty_n = (w_cnt_n == '0);
    if (FWFT != 0) w_empty_n = ~w_ovalid_n;
  end

  // Pointers, occupancy and registered flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_cnt     <= '0;
      r_ram_cnt <= '0;
      r_full    <= 1'b0;
      r_afull   <= 1'b0;
      r_empty   <= 1'b1;
      r_aempty  <= 1'b1;
      r_ovf     <= 1'b0;
      r_udf     <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + P_ONE;
      if (w_rd) r_rd_ptr <= r_rd_ptr + P_ONE;
      r_cnt     <= w_cnt_n;
      r_ram_cnt <= w_ram_cnt_n;
      r_full    <= (w_cnt_n == C_DEPTH);
      r_afull   <= (w_cnt_n >= C_AF);
      r_empty   <= w_empty_n;
      r_aempty  <= (w_cnt_n <= C_AE);
      r_ovf     <= wr_en & r_full;
      r_udf     <= rd_en & r_empty;
    end
  end

  // FWFT staging: RAM read register feeds the output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovalid <= 1'b0;
      r_mvalid <= 1'b0;
      r_dout   <= '0;
    end else begin
      r_ovalid <= w_ovalid_n;
      r_mvalid <= w_mvalid_n;
      if (w_load) r_dout <= w_ram_rdata;
    end
  end

  sdpram_sc #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .wr_en  (w_push),
    .wr_addr(r_wr_ptr),
    .wr_data(wr_data),
    .rd_en  (w_rd),
    .rd_addr(r_rd_ptr),
    .rd_data(w_ram_rdata)
  );

  assign full         = r_full;
  assign almost_full  = r_afull;
  assign overflow     = r_ovf;
  assign empty        = r_empty;
  assign almost_empty = r_aempty;
  assign underflow    = r_udf;
  assign data_count   = r_cnt;
  assign rd_data      = (FWFT != 0) ? r_dout : w_ram_rdata;

endmodule

// File: tb/tb_sync_fifo_sdpram.sv
// Bench for sync_fifo_sdpram: standard and FWFT instances
// driven together, each checked against a queue model.
module tb_sync_fifo_sdpram;

  localparam int DW    = 20;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AFT   = 12;
  localparam int AET   = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [DW-1:0] d;
    int            t;
  } ent_t;

  // g=0 standard read, g=1 first-word-fall-through
  for (genvar g = 0; g < 2; g++) begin : g_m
    localparam int LAT = (g == 0) ? 0 : 2;

    logic          full;
    logic          afull;
    logic          ovf;
    logic          empty;
    logic          aempty;
    logic          udf;
    logic [DW-1:0] rdata;
    logic [AW:0]   cnt;

    ent_t          q[$];
    int            ne = 0;
    logic [DW-1:0] last = '0;
    logic          eovf = 1'b0;
    logic          eudf = 1'b0;

    // A word pushed at edge T may be popped at edge T+1 (standard)
    // or T+3 (FWFT); ne+1 is the number of the coming edge.
    function automatic bit m_empty();
      if (q.size() == 0) return 1'b1;
      return (q[0].t + LAT) >= (ne + 1);
    endfunction

    sync_fifo_sdpram #(
      .DATA_WIDTH     (DW),
      .ADDR_WIDTH     (AW),
      .FWFT           (g),
      .ALMOST_FULL_TH (AFT),
      .ALMOST_EMPTY_TH(AET)
    ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .full        (full),
      .almost_full (afull),
      .overflow    (ovf),
      .rd_en       (rd_en),
      .rd_data     (rdata),
      .empty       (empty),
      .almost_empty(aempty),
      .underflow   (udf),
      .data_count  (cnt)
    );

    always @(posedge clk or posedge rst) begin
      if (rst) begin
        q.delete();
        last <= '0;
        eovf <= 1'b0;
        eudf <= 1'b0;
      end else begin
        eovf <= wr_en && (q.size() == DEPTH);
        eudf <= rd_en && m_empty();
        if (wr_en && q.size() < DEPTH) q.push_back('{wr_data, ne + 1});
        if (rd_en && !m_empty()) begin
          last <= q[0].d;
          q.pop_front();
        end
        ne <= ne + 1;
      end
    end

    always @(negedge clk) begin
      if (!rst) begin
        chk($sformatf("m%0d count", g), 32'(cnt), q.size());
        chk($sformatf("m%0d full", g), 32'(full), 32'(q.size() == DEPTH));
        chk($sformatf("m%0d almost_full", g), 32'(afull),
            32'(q.size() >= AFT));
        chk($sformatf("m%0d almost_empty", g), 32'(aempty),
            32'(q.size() <= AET));
        chk($sformatf("m%0d empty", g), 32'(empty), 32'(m_empty()));
        chk($sformatf("m%0d overflow", g), 32'(ovf), 32'(eovf));
        chk($sformatf("m%0d underflow", g), 32'(udf), 32'(eudf));
        if (LAT == 0 || !m_empty())
          chk($sformatf("m%0d rd_data", g), 32'(rdata),
              32'((LAT == 0) ? last : q[0].d));
      end
    end
  end

  task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r);
    wr_en   = w;
    wr_data = d;
    rd_en   = r;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  task automatic rst_vals();
    chk("s empty rst", 32'(g_m[0].empty), 1);
    chk("f empty rst", 32'(g_m[1].empty), 1);
    chk("s aempty rst", 32'(g_m[0].aempty), 1);
    chk("f aempty rst", 32'(g_m[1].aempty), 1);
    chk("s full rst", 32'(g_m[0].full), 0);
    chk("f full rst", 32'(g_m[1].full), 0);
    chk("s afull rst", 32'(g_m[0].afull), 0);
    chk("f afull rst", 32'(g_m[1].afull), 0);
    chk("s ovf rst", 32'(g_m[0].ovf), 0);
    chk("f ovf rst", 32'(g_m[1].ovf), 0);
    chk("s udf rst", 32'(g_m[0].udf), 0);
    chk("f udf rst", 32'(g_m[1].udf), 0);
    chk("s rdata rst", 32'(g_m[0].rdata), 0);
    chk("f rdata rst", 32'(g_m[1].rdata), 0);
    chk("s count rst", 32'(g_m[0].cnt), 0);
    chk("f count rst", 32'(g_m[1].cnt), 0);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1 rst_vals();
    repeat (2) @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;

    // fill 1..16, then overflow with a simultaneous read
    for (int i = 1; i <= DEPTH; i++) cyc(1'b1, DW'(i), 1'b0);
    chk("s full16", 32'(g_m[0].full), 1);
    chk("f full16", 32'(g_m[1].full), 1);
    chk("s count16", 32'(g_m[0].cnt), 16);
    chk("f count16", 32'(g_m[1].cnt), 16);
    idle(3);
    cyc(1'b1, 20'hFFFFF, 1'b1);
    chk("s ovf pulse", 32'(g_m[0].ovf), 1);
    chk("f ovf pulse", 32'(g_m[1].ovf), 1);
    chk("s count15", 32'(g_m[0].cnt), 15);
    chk("f count15", 32'(g_m[1].cnt), 15);
    chk("s first pop", 32'(g_m[0].rdata), 32'h1);
    chk("f head2", 32'(g_m[1].rdata), 32'h2);
    idle(1);
    chk("s ovf drop", 32'(g_m[0].ovf), 0);

    // drain the rest back to back, then two reads on empty
    for (int i = 0; i < DEPTH - 1; i++) cyc(1'b0, '0, 1'b1);
    chk("s last pop", 32'(g_m[0].rdata), 32'h10);
    chk("s empty drained", 32'(g_m[0].empty), 1);
    chk("f empty drained", 32'(g_m[1].empty), 1);
    cyc(1'b0, '0, 1'b1);
    cyc(1'b0, '0, 1'b1);

    // underflow with a simultaneous write
    cyc(1'b1, 20'hABCDE, 1'b1);
    chk("s udf pulse", 32'(g_m[0].udf), 1);
    chk("f udf pulse", 32'(g_m[1].udf), 1);
    chk("s count1", 32'(g_m[0].cnt), 1);
    chk("f count1", 32'(g_m[1].cnt), 1);
    idle(3);
    chk("f head abcde", 32'(g_m[1].rdata), 32'hABCDE);
    cyc(1'b0, '0, 1'b1);
    chk("s pop abcde", 32'(g_m[0].rdata), 32'hABCDE);

    // write-to-visible latency
    cyc(1'b1, 20'h12345, 1'b0);
    chk("s lat empty0", 32'(g_m[0].empty), 0);
    chk("f lat empty1", 32'(g_m[1].empty), 1);
    chk("f lat count1", 32'(g_m[1].cnt), 1);
    idle(1);
    chk("f lat empty1b", 32'(g_m[1].empty), 1);
    idle(1);
    chk("f lat empty0", 32'(g_m[1].empty), 0);
    chk("f lat data", 32'(g_m[1].rdata), 32'h12345);
    cyc(1'b0, '0, 1'b1);
    chk("s lat data", 32'(g_m[0].rdata), 32'h12345);

    // steady state at count 5 across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, DW'(32'h100 + i), 1'b0);
    idle(3);
    for (int i = 0; i < 100; i++) cyc(1'b1, DW'(32'h200 + i), 1'b1);
    chk("s steady count", 32'(g_m[0].cnt), 5);
    chk("f steady count", 32'(g_m[1].cnt), 5);
    chk("s steady aempty", 32'(g_m[0].aempty), 0);
    chk("f steady afull", 32'(g_m[1].afull), 0);
    chk("s steady data", 32'(g_m[0].rdata), 32'h25E);
    chk("f steady head", 32'(g_m[1].rdata), 32'h25F);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
    idle(2);

    // random traffic at three push/pop mixes
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 300; i++) begin
        int pw;
        pw = (p == 0) ? 70 : (p == 1) ? 30 : 50;
        cyc(1'(($urandom % 100) < pw), DW'($urandom),
            1'(($urandom % 100) < (100 - pw)));
      end
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, '0, 1'b1);
    idle(2);

    // asynchronous reset at count 9, then a round trip
    for (int i = 0; i < 9; i++) cyc(1'b1, DW'(32'h300 + i), 1'b0);
    idle(3);
    chk("s count9", 32'(g_m[0].cnt), 9);
    chk("f count9", 32'(g_m[1].cnt), 9);
    #3 rst = 1'b1;
    #1 rst_vals();
    @(posedge clk);
    #4 rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b1, 20'h00077, 1'b0);
    idle(3);
    chk("f post rst head", 32'(g_m[1].rdata), 32'h77);
    cyc(1'b0, '0, 1'b1);
    chk("s post rst data", 32'(g_m[0].rdata), 32'h77);
    chk("s post rst count", 32'(g_m[0].cnt), 0);
    chk("f post rst count", 32'(g_m[1].cnt), 0);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
